// File: rtl/sd_spi_card_responder_if.sv
// Byte-slot link between an SPI slave shifter (host side of this bus) and the
// SD card responder.
interface sd_spi_card_responder_if;
    logic       cs_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       in_idle;
    logic       initialized;
    logic       cmd_strobe;
    logic [5:0] cmd_index;

    modport master (
        output cs_n, rx_byte, rx_valid,
        input  tx_byte, in_idle, initialized, cmd_strobe, cmd_index
    );

    modport slave (
        input  cs_n, rx_byte, rx_valid,
        output tx_byte, in_idle, initialized, cmd_strobe, cmd_index
    );
endinterface

// File: rtl/sd_spi_card_responder.sv
// Byte-level SD SPI-mode card responder: frames 6-byte commands, checks CRC7 and
// answers CMD0/8/55/ACMD41/58 with R1/R7/R3 after NCR filler slots.
module sd_spi_card_responder #(
    parameter int          NCR         = 1,
    parameter int          ACMD41_BUSY = 2,
    parameter logic [31:0] OCR         = 32'hC0FF8000,
    parameter int          CRC_CHECK   = 0
) (
    input logic clk,
    input logic rst,
    sd_spi_card_responder_if.slave bus
);

    typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_NCR, S_RESP} state_t;

    localparam logic [2:0] NCR_LAST = 3'(NCR - 1);
    localparam logic [7:0] BUSY_LIM = 8'(ACMD41_BUSY);

    state_t     state, state_n;
    logic [7:0] tx_q, tx_n;
    logic       idle_q, idle_n;
    logic       app_q, app_n;
    logic [7:0] busy_q, busy_n;
    logic [5:0] idx_q, idx_n;
    logic       strobe_q, strobe_n;
    logic [2:0] ncnt_q, ncnt_n;
    logic [2:0] ridx_q, ridx_n;
    logic [2:0] rlen_q, rlen_n;
    logic [2:0] bcnt_q, bcnt_n;
    logic [6:0] crc_q, crc_n;
    logic [11:0] arg_q, arg_n;
    logic [5:0] fidx_q, fidx_n;
    logic [7:0] resp_q [0:4];
    logic [7:0] resp_n [0:4];
    logic       checked;
    logic       crc_err;

    // Shift one byte MSB first through CRC7 (x^7 + x^3 + 1).
    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
        logic [6:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[6] ^ d[i];
            r  = {r[5:0], 1'b0};
            if (fb) r = r ^ 7'h09;
        end
        return r;
    endfunction

    always_comb begin
        state_n  = state;
        tx_n     = tx_q;
        idle_n   = idle_q;
        app_n    = app_q;
        busy_n   = busy_q;
        idx_n    = idx_q;
        strobe_n = 1'b0;
        ncnt_n   = ncnt_q;
        ridx_n   = ridx_q;
        rlen_n   = rlen_q;
        bcnt_n   = bcnt_q;
        crc_n    = crc_q;
        arg_n    = arg_q;
        fidx_n   = fidx_q;
        resp_n   = resp_q;
        checked  = (CRC_CHECK != 0) || (fidx_q == 6'd0) || (fidx_q == 6'd8);
        crc_err  = checked && (bus.rx_byte != {crc_q, 1'b1});

        if (bus.cs_n) begin
            state_n = S_HUNT;
            tx_n    = 8'hFF;
        end else if (bus.rx_valid) begin
            case (state)
                S_HUNT: begin
                    tx_n = 8'hFF;
                    if (bus.rx_byte[7:6] == 2'b01) begin
                        fidx_n  = bus.rx_byte[5:0];
                        crc_n   = crc7_byte(7'h00, bus.rx_byte);
                        bcnt_n  = 3'd0;
                        state_n = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (bcnt_q != 3'd4) begin
                        arg_n  = {arg_q[3:0], bus.rx_byte};
                        crc_n  = crc7_byte(crc_q, bus.rx_byte);
                        bcnt_n = bcnt_q + 3'd1;
                    end else begin
                        idx_n     = fidx_q;
                        strobe_n  = 1'b1;
                        tx_n      = 8'hFF;
                        state_n   = S_NCR;
                        ncnt_n    = 3'd0;
                        ridx_n    = 3'd1;
                        rlen_n    = 3'd1;
                        app_n     = 1'b0;
                        resp_n[1] = 8'h00;
                        resp_n[2] = 8'h00;
                        resp_n[3] = 8'h00;
                        resp_n[4] = 8'h00;
                        if (crc_err) begin
                            resp_n[0] = {4'b0000, 1'b1, 2'b00, idle_q};
                        end else begin
                            case (fidx_q)
                                6'd0: begin
                                    idle_n    = 1'b1;
                                    busy_n    = 8'd0;
                                    resp_n[0] = 8'h01;
                                end
                                6'd8: begin
                                    resp_n[0] = {7'b0, idle_q};
                                    resp_n[3] = {4'h0, arg_q[11:8]};
                                    resp_n[4] = arg_q[7:0];
                                    rlen_n    = 3'd5;
                                end
                                6'd55: begin
                                    resp_n[0] = {7'b0, idle_q};
                                    app_n     = 1'b1;
                                end
                                6'd41: begin
                                    if (!app_q) begin
                                        resp_n[0] = {5'b0, 1'b1, 1'b0, idle_q};
                                    end else if (busy_q < BUSY_LIM) begin
                                        busy_n    = busy_q + 8'd1;
                                        resp_n[0] = 8'h01;
                                    end else begin
                                        idle_n    = 1'b0;
                                        resp_n[0] = 8'h00;
                                    end
                                end
                                6'd58: begin
                                    // OCR power-up bit stays clear until init completes.
                                    resp_n[0] = {7'b0, idle_q};
                                    resp_n[1] = {OCR[31] & ~idle_q, OCR[30:24]};
                                    resp_n[2] = OCR[23:16];
                                    resp_n[3] = OCR[15:8];
                                    resp_n[4] = OCR[7:0];
                                    rlen_n    = 3'd5;
                                end
                                default: resp_n[0] = {5'b0, 1'b1, 1'b0, idle_q};
                            endcase
                        end
                    end
                end
                S_NCR: begin
                    if (ncnt_q == NCR_LAST) begin
                        tx_n    = resp_q[0];
                        state_n = S_RESP;
                    end else begin
                        tx_n   = 8'hFF;
                        ncnt_n = ncnt_q + 3'd1;
                    end
                end
                default: begin
                    if (ridx_q < rlen_q) begin
                        tx_n   = resp_q[ridx_q];
                        ridx_n = ridx_q + 3'd1;
                    end else begin
                        tx_n    = 8'hFF;
                        state_n = S_HUNT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HUNT;
            tx_q     <= 8'hFF;
            idle_q   <= 1'b1;
            app_q    <= 1'b0;
            busy_q   <= 8'd0;
            idx_q    <= 6'd0;
            strobe_q <= 1'b0;
            ncnt_q   <= 3'd0;
            ridx_q   <= 3'd0;
            rlen_q   <= 3'd1;
        end else begin
            state    <= state_n;
            tx_q     <= tx_n;
            idle_q   <= idle_n;
            app_q    <= app_n;
            busy_q   <= busy_n;
            idx_q    <= idx_n;
            strobe_q <= strobe_n;
            ncnt_q   <= ncnt_n;
            ridx_q   <= ridx_n;
            rlen_q   <= rlen_n;
        end
    end

    // Frame payload registers carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        bcnt_q <= bcnt_n;
        crc_q  <= crc_n;
        arg_q  <= arg_n;
        fidx_q <= fidx_n;
        resp_q <= resp_n;
    end

    assign bus.tx_byte     = tx_q;
    assign bus.in_idle     = idle_q;
    assign bus.initialized = ~idle_q;
    assign bus.cmd_strobe  = strobe_q;
    assign bus.cmd_index   = idx_q;

endmodule
